// File: rtl/ecc_scrub_pkg.sv
// Shared types and defaults for the cache-bank ECC scrub controller.
package ecc_scrub_pkg;

   typedef enum logic [1:0] {
      Idle  = 2'd0,
      Wait  = 2'd1,
      Scrub = 2'd2
   } scrub_ctrl_state_e;

   localparam int unsigned TimeoutCyclesDefault = 32'd1024;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter: holds at all-ones, clear takes priority over increment.
module ecc_sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [Width-1:0] cnt_o,
   output logic             at_max_o
);

   logic [Width-1:0] cnt_r;

   // Count register with clear beating a same-cycle increment
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= {Width{1'b0}};
      end else if (clr_i) begin
         cnt_r <= {Width{1'b0}};
      end else if (inc_i && !at_max_o) begin
         cnt_r <= cnt_r + Width'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt_o    = cnt_r;
   assign at_max_o = &cnt_r;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Scrub scheduler and error-event collector for the cache-bank ECC scrubber.
// Optional error-address log enabled by defining ECC_SCRUB_CTRL_LOG_EN.
module ecc_scrub_ctrl
   import ecc_scrub_pkg::*;
#(
   parameter int unsigned CntWidth      = 16,
   parameter int unsigned IntervalWidth = 20,
   parameter int unsigned BurstWidth    = 8,
   parameter int unsigned TimeoutCycles = TimeoutCyclesDefault,
   parameter int unsigned AddrWidth     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic [IntervalWidth-1:0] interval_i,
   input  logic [BurstWidth-1:0]    burst_len_i,
   input  logic [CntWidth-1:0]      corr_thresh_i,
   input  logic                     clear_i,
   output logic                     scrub_trigger_o,
   input  logic                     scrub_done_i,
   input  logic                     bit_corrected_i,
   input  logic                     uncorrectable_i,
   input  logic [AddrWidth-1:0]     scrub_addr_i,
   output logic [CntWidth-1:0]      corr_cnt_o,
   output logic [CntWidth-1:0]      uncorr_cnt_o,
   output logic                     irq_o,
   output logic                     stall_o
`ifdef ECC_SCRUB_CTRL_LOG_EN
   ,
   output logic [AddrWidth-1:0]     err_addr_o,
   output logic                     err_addr_vld_o
`endif
);

   localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);
   localparam logic [TimeoutW-1:0] TimeoutLoad = TimeoutW'(TimeoutCycles);

   scrub_ctrl_state_e         state_r, state_nxt_s;
   logic [IntervalWidth-1:0]  interval_cnt_r, interval_nxt_s;
   logic [BurstWidth-1:0]     burst_cnt_r, burst_nxt_s;
   logic [TimeoutW-1:0]       timeout_cnt_r, timeout_nxt_s;
   logic                      stall_set_s;
   logic                      irq_r, stall_r;
   logic [CntWidth-1:0]       corr_cnt_s, corr_next_s;
   logic                      corr_at_max_s;
   logic                      unused_uncorr_max_s;
   logic                      irq_set_s;

   // Next-state and working-counter logic; disable overrides every state
   always_comb begin
      state_nxt_s    = state_r;
      interval_nxt_s = interval_cnt_r;
      burst_nxt_s    = burst_cnt_r;
      timeout_nxt_s  = timeout_cnt_r;
      stall_set_s    = 1'b0;
      if (!enable_i) begin
         state_nxt_s = Idle;
      end else begin
         case (state_r)
            Idle: begin
               state_nxt_s    = Wait;
               interval_nxt_s = interval_i;
            end
            Wait: begin
               // a loaded value of 0 or 1 both mean a single idle cycle
               if (interval_cnt_r <= IntervalWidth'(1'b1)) begin
                  state_nxt_s   = Scrub;
                  timeout_nxt_s = TimeoutLoad;
                  if (burst_len_i == {BurstWidth{1'b0}}) begin
                     burst_nxt_s = BurstWidth'(1'b1);
                  end else begin
                     burst_nxt_s = burst_len_i;
                  end
               end else begin
                  interval_nxt_s = interval_cnt_r - IntervalWidth'(1'b1);
               end
            end
            Scrub: begin
               if (scrub_done_i) begin
                  timeout_nxt_s = TimeoutLoad;
                  if (burst_cnt_r <= BurstWidth'(1'b1)) begin
                     state_nxt_s    = Wait;
                     interval_nxt_s = interval_i;
                     burst_nxt_s    = {BurstWidth{1'b0}};
                  end else begin
                     burst_nxt_s = burst_cnt_r - BurstWidth'(1'b1);
                  end
               end else if (timeout_cnt_r <= TimeoutW'(1'b1)) begin
                  stall_set_s    = 1'b1;
                  state_nxt_s    = Wait;
                  interval_nxt_s = interval_i;
               end else begin
                  timeout_nxt_s = timeout_cnt_r - TimeoutW'(1'b1);
               end
            end
            default: begin
               state_nxt_s = Idle;
            end
         endcase
      end
   end

   // State and working-counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= Idle;
         interval_cnt_r <= {IntervalWidth{1'b0}};
         burst_cnt_r    <= {BurstWidth{1'b0}};
         timeout_cnt_r  <= {TimeoutW{1'b0}};
      end else begin
         state_r        <= state_nxt_s;
         interval_cnt_r <= interval_nxt_s;
         burst_cnt_r    <= burst_nxt_s;
         timeout_cnt_r  <= timeout_nxt_s;
      end
   end

   assign scrub_trigger_o = (state_r == Scrub);

   ecc_sat_counter #(.Width(CntWidth)) u_corr_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (bit_corrected_i),
      .clr_i    (clear_i),
      .cnt_o    (corr_cnt_s),
      .at_max_o (corr_at_max_s)
   );

   ecc_sat_counter #(.Width(CntWidth)) u_uncorr_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (uncorrectable_i),
      .clr_i    (clear_i),
      .cnt_o    (uncorr_cnt_o),
      .at_max_o (unused_uncorr_max_s)
   );

   assign corr_cnt_o = corr_cnt_s;

   // Threshold is judged on the value the corrected counter is about to take
   always_comb begin
      if (bit_corrected_i && !corr_at_max_s) begin
         corr_next_s = corr_cnt_s + CntWidth'(1'b1);
      end else begin
         corr_next_s = corr_cnt_s;
      end
      if (uncorrectable_i) begin
         irq_set_s = 1'b1;
      end else if ((corr_thresh_i != {CntWidth{1'b0}}) && (corr_next_s >= corr_thresh_i)) begin
         irq_set_s = 1'b1;
      end else begin
         irq_set_s = 1'b0;
      end
   end

   // Sticky irq and stall flags; clear wins over a same-cycle set
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_r   <= 1'b0;
         stall_r <= 1'b0;
      end else if (clear_i) begin
         irq_r   <= 1'b0;
         stall_r <= 1'b0;
      end else begin
         irq_r   <= irq_r | irq_set_s;
         stall_r <= stall_r | stall_set_s;
      end
   end

   assign irq_o   = irq_r;
   assign stall_o = stall_r;

`ifdef ECC_SCRUB_CTRL_LOG_EN
   logic [AddrWidth-1:0] err_addr_r;
   logic                 err_addr_vld_r;

   // Capture only the first uncorrectable address since reset or clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_addr_r     <= {AddrWidth{1'b0}};
         err_addr_vld_r <= 1'b0;
      end else if (clear_i) begin
         err_addr_r     <= {AddrWidth{1'b0}};
         err_addr_vld_r <= 1'b0;
      end else if (uncorrectable_i && !err_addr_vld_r) begin
         err_addr_r     <= scrub_addr_i;
         err_addr_vld_r <= 1'b1;
      end else begin
         err_addr_r     <= err_addr_r;
         err_addr_vld_r <= err_addr_vld_r;
      end
   end

   assign err_addr_o     = err_addr_r;
   assign err_addr_vld_o = err_addr_vld_r;
`else
   logic unused_addr_s;
   assign unused_addr_s = ^scrub_addr_i;
`endif

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Upstream scheduler and downstream event collector for the cache-bank ECC scrubber.
- Generates the scrubber's `scrub_trigger` as periodic bursts of N scrubbed lines.
- Consumes the scrubber's `bit_corrected` / `uncorrectable` / step-done pulses, keeps saturating error counters, raises an interrupt on threshold, and flags a stalled scrubber.

Parameters:
- CntWidth, 16, width of error counters and threshold.
- IntervalWidth, 20, width of idle-interval counter.
- BurstWidth, 8, width of burst-length counter.
- TimeoutCycles, 1024, max cycles in Scrub without a step-done before stall is flagged.
- AddrWidth, 8, scrubber address width (used by the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  scheduler enable; 0 forces Idle.
- interval_i  in  IntervalWidth  idle cycles between bursts; sampled on each entry to Wait.
- burst_len_i  in  BurstWidth  scrub steps per burst; 0 is treated as 1.
- corr_thresh_i  in  CntWidth  irq when corr_cnt_o reaches this; 0 disables.
- clear_i  in  1  clears counters, irq_o and stall_o.
- scrub_trigger_o  out  1  drives scrubber scrub_trigger.
- scrub_done_i  in  1  one-cycle pulse per completed scrub step (scrubber Write→Idle).
- bit_corrected_i  in  1  scrubber correctable-error pulse.
- uncorrectable_i  in  1  scrubber uncorrectable-error pulse.
- scrub_addr_i  in  AddrWidth  scrubber working address.
- corr_cnt_o  out  CntWidth  saturating correctable count.
- uncorr_cnt_o  out  CntWidth  saturating uncorrectable count.
- irq_o  out  1  sticky interrupt.
- stall_o  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0, state Idle, internal counters 0.
- FSM states: Idle, Wait, Scrub.
- Idle:
  - scrub_trigger_o=0.
  - enable_i=1 → Wait; load interval counter with interval_i.
- Wait:
  - Decrement each cycle.
  - At 0 → Scrub; load burst counter with max(burst_len_i,1) and timeout counter with TimeoutCycles.
  - interval_i=0 → Scrub the cycle after entry.
- Scrub:
  - scrub_trigger_o=1 combinationally from state.
  - Each scrub_done_i decrements the burst counter and reloads the timeout counter.
  - If scrub_done_i arrives with burst counter==1 → Wait (reload interval); trigger deasserts the next cycle.
  - Timeout counter decrements on cycles without scrub_done_i.
  - Timeout reaching 0 → stall_o=1, → Wait.
- enable_i=0 in any state → Idle next cycle; burst is abandoned and the counters are preserved.
- Counters:
  - bit_corrected_i / uncorrectable_i each increment their counter by 1 per cycle high, saturating at all-ones.
  - Counting is independent of FSM state, since the scrubber may finish a step after the trigger drops.
- irq_o:
  - Set when the corr counter's next value ≥ corr_thresh_i (thresh≠0), or on any uncorrectable_i.
  - Sticky until clear_i.
- clear_i:
  - Zeroes the counters and drops irq_o and stall_o next cycle.
  - clear_i wins over a same-cycle increment or set.
  - FSM is unaffected.
- rst_i mid-burst → Idle, trigger low next edge.

Optional Feature:
- Macro ECC_SCRUB_CTRL_LOG_EN.
- With the macro:
  - Extra outputs err_addr_o [AddrWidth] and err_addr_vld_o.
  - On the first uncorrectable_i since reset/clear, capture scrub_addr_i; set vld.
  - Later errors do not overwrite; clear_i resets both.
- Without the macro: the ports and capture register are absent.

Decomposition:
- Package ecc_scrub_pkg holds:
  - the state enum scrub_ctrl_state_e {Idle, Wait, Scrub};
  - the default TimeoutCycles constant.
- Sub-module ecc_sat_counter (parameter Width; inc, clr, cnt, at_max), instantiated twice.

Test Plan:
- Schedule: interval_i=5, burst_len_i=3, scrubber model pulses done every 4 cycles → trigger low 5 cycles, high until the 3rd done, low 5 cycles, repeating.
- Saturation: CntWidth=4, 20 bit_corrected_i pulses → corr_cnt_o=15, no wrap.
- Threshold: corr_thresh_i=3, 3 corrected pulses → irq_o=1 on the cycle after the 3rd; clear_i → irq_o=0, corr_cnt_o=0.
- Stall: TimeoutCycles=16, no scrub_done_i in Scrub → stall_o=1 after 16 cycles, FSM back in Wait.
- Abort and reset: enable_i=0 mid-burst → trigger 0 next cycle; rst_i with counters nonzero → all outputs 0 next edge.
- Optional feature (LOG_EN): uncorrectable at addr 0x2A, then at 0x30 → err_addr_o=0x2A, vld=1.
